// File: rtl/cpu_pkg.sv
// Shared opcode, instruction-word and FSM definitions for the
// instruction encoder and its decode logic.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b11;
  localparam logic [1:0] OP_NOP = 2'b10;

  localparam logic [7:0] NOP_WORD = {OP_NOP, 6'b000000};

  // Control intent as {Branch, ALU_OP, Reg_Write}
  localparam logic [2:0] CTL_ADD = 3'b001;
  localparam logic [2:0] CTL_SLL = 3'b011;
  localparam logic [2:0] CTL_BR  = 3'b100;
  localparam logic [2:0] CTL_NOP = 3'b000;

  typedef struct packed {
    logic [7:0] word;
    logic       bad;
  } enc_t;

  function automatic enc_t encode(
    input logic [2:0] ctl,
    input logic [2:0] rd,
    input logic [2:0] rs,
    input logic [5:0] off
  );
    enc_t e;
    e.word = NOP_WORD;
    e.bad  = 1'b0;
    unique case (1'b1)
      (ctl == CTL_ADD): e.word = {OP_ADD, rd, rs};
      (ctl == CTL_SLL): e.word = {OP_SLL, rd, rs};
      (ctl == CTL_BR):  e.word = {OP_BR, off};
      (ctl == CTL_NOP): e.word = NOP_WORD;
      default:          e.bad  = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding encoded words between
// request acceptance and the instruction-memory write port.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/instr_encoder.sv
// Encodes control requests into 8-bit instructions and streams
// them into instruction memory from a latched base address.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] Base_Addr,
  input  logic [7:0] Count,
  input  logic       Req_Valid,
  output logic       Req_Ready,
  input  logic       Req_Branch,
  input  logic       Req_ALU_OP,
  input  logic       Req_Reg_Write,
  input  logic [2:0] Req_Rd,
  input  logic [2:0] Req_Rs,
  input  logic [5:0] Req_Offset,
  output logic       Mem_WE,
  output logic [7:0] Mem_Addr,
  output logic [7:0] Mem_WData,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_count;
  logic [7:0] r_acc;
  logic [7:0] r_wr;
  logic [7:0] r_addr;
  logic       r_err;

  enc_t       w_enc;
  logic [7:0] w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_start;
  logic       w_push;
  logic       w_pop;

  assign w_enc = encode({Req_Branch, Req_ALU_OP, Req_Reg_Write},
                        Req_Rd, Req_Rs, Req_Offset);

  assign w_start = Start && (r_state == ST_IDLE);
  assign w_push  = Req_Valid && Req_Ready;
  assign w_pop   = (r_state == ST_LOAD) && !w_empty;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .i_push  (w_push),
    .i_wdata (w_enc.word),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (Start) w_next = (Count != 8'd0) ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        if (r_wr == r_count) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy      = (r_state == ST_LOAD);
    Done      = (r_state == ST_DONE);
    Req_Ready = (r_state == ST_LOAD) && !w_full &&
                (r_acc < r_count);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count   <= '0;
      r_acc     <= '0;
      r_wr      <= '0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      Mem_WE    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
    end else begin
      Mem_WE <= w_pop;
      if (w_start) begin
        r_count <= Count;
        r_addr  <= Base_Addr;
        r_acc   <= '0;
        r_wr    <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_push) r_acc <= r_acc + 8'd1;
        if (w_push && w_enc.bad) r_err <= 1'b1;
        // Address register wraps naturally at 8 bits
        if (w_pop) begin
          Mem_WData <= w_head;
          Mem_Addr  <= r_addr;
          r_addr    <= r_addr + 8'd1;
          r_wr      <= r_wr + 8'd1;
        end
      end
    end
  end

  assign Err = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: randomised and directed loads
// checked against a word/address reference model.
module tb_instr_encoder;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Base_Addr = '0;
  logic [7:0] Count = '0;
  logic       Req_Valid = 1'b0;
  logic       Req_Ready;
  logic       Req_Branch = 1'b0;
  logic       Req_ALU_OP = 1'b0;
  logic       Req_Reg_Write = 1'b0;
  logic [2:0] Req_Rd = '0;
  logic [2:0] Req_Rs = '0;
  logic [5:0] Req_Offset = '0;
  logic       Mem_WE;
  logic [7:0] Mem_Addr;
  logic [7:0] Mem_WData;
  logic       Busy;
  logic       Done;
  logic       Err;

  instr_encoder #(.DEPTH(4)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Start         (Start),
    .Base_Addr     (Base_Addr),
    .Count         (Count),
    .Req_Valid     (Req_Valid),
    .Req_Ready     (Req_Ready),
    .Req_Branch    (Req_Branch),
    .Req_ALU_OP    (Req_ALU_OP),
    .Req_Reg_Write (Req_Reg_Write),
    .Req_Rd        (Req_Rd),
    .Req_Rs        (Req_Rs),
    .Req_Offset    (Req_Offset),
    .Mem_WE        (Mem_WE),
    .Mem_Addr      (Mem_Addr),
    .Mem_WData     (Mem_WData),
    .Busy          (Busy),
    .Done          (Done),
    .Err           (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] ctl;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [5:0] off;
  } req_t;

  req_t        req_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  mdl_addr;
  bit          mdl_err;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic req_t mk(logic [2:0] c, logic [2:0] d,
                              logic [2:0] s, logic [5:0] o);
    req_t r;
    r.ctl = c; r.rd = d; r.rs = s; r.off = o;
    return r;
  endfunction

  // Reference: add = rd*8+rs, sll = 64+rd*8+rs,
  // branch = 192+offset, nop and illegal = 128
  function automatic logic [7:0] ref_word(req_t r);
    int w;
    if (r.ctl == 3'd1)      w = r.rd * 8 + r.rs;
    else if (r.ctl == 3'd3) w = 64 + r.rd * 8 + r.rs;
    else if (r.ctl == 3'd4) w = 192 + r.off;
    else                    w = 128;
    return w[7:0];
  endfunction

  function automatic bit ref_bad(req_t r);
    return !(r.ctl == 3'd0 || r.ctl == 3'd1 ||
             r.ctl == 3'd3 || r.ctl == 3'd4);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (Mem_WE === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write actual=%h@%h required=none",
                 Mem_WData, Mem_Addr);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({Mem_Addr, Mem_WData} !== e) begin
          n_err++;
          $display("FAIL mem_write actual=%h@%h required=%h@%h",
                   Mem_WData, Mem_Addr, e[7:0], e[15:8]);
        end
      end
    end
  end

  task automatic drive_req(req_t r);
    Req_Branch    = r.ctl[2];
    Req_ALU_OP    = r.ctl[1];
    Req_Reg_Write = r.ctl[0];
    Req_Rd        = r.rd;
    Req_Rs        = r.rs;
    Req_Offset    = r.off;
  endtask

  task automatic do_load(input logic [7:0] base, input logic [7:0] cnt,
                         input bit full_rate, output int rdy_n,
                         output int max_run, output int done_n,
                         output int first_done);
    int idx;
    int run;
    idx = 0; run = 0;
    rdy_n = 0; max_run = 0; done_n = 0; first_done = -1;
    @(negedge Clk);
    Start = 1'b1; Base_Addr = base; Count = cnt;
    mdl_addr = base; mdl_err = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      Req_Valid = (idx < req_q.size()) &&
                  (full_rate || $urandom_range(0, 3) != 0);
      if (idx < req_q.size()) drive_req(req_q[idx]);
      #1;
      if (Req_Ready) rdy_n++;
      if (Mem_WE) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (Done) begin
        done_n++;
        if (first_done < 0) first_done = c;
      end
      if (Req_Valid && Req_Ready) begin
        exp_q.push_back({mdl_addr, ref_word(req_q[idx])});
        if (ref_bad(req_q[idx])) mdl_err = 1'b1;
        mdl_addr = mdl_addr + 8'd1;
        idx++;
      end
      if (first_done >= 0 && c >= first_done + 2) break;
      @(negedge Clk);
    end
    Req_Valid = 1'b0;
  endtask

  task automatic post_check(string nm, int done_n, int first_done);
    chk({nm, "_done_seen"}, first_done >= 0, 1);
    chk({nm, "_done_width"}, done_n, 1);
    chk({nm, "_err"}, Err, mdl_err);
    chk({nm, "_all_written"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_n, max_run, done_n, first_done, wes;
    #1 Reset_n = 1'b0;
    #2;
    chk("rst_we", Mem_WE, 0);
    chk("rst_addr", Mem_Addr, 0);
    chk("rst_wdata", Mem_WData, 0);
    chk("rst_ready", Req_Ready, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Err, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    req_q = {mk(3'b001, 3'd2, 3'd5, 6'h00),
             mk(3'b011, 3'd1, 3'd3, 6'h00),
             mk(3'b100, 3'd0, 3'd0, 6'h2A)};
    do_load(8'h10, 8'd3, 1'b0, rdy_n, max_run, done_n, first_done);
    post_check("basic", done_n, first_done);

    req_q = {mk(3'b000, 3'd7, 3'd7, 6'h3F),
             mk(3'b000, 3'd0, 3'd1, 6'h01),
             mk(3'b000, 3'd5, 3'd2, 6'h10)};
    do_load(8'hFE, 8'd3, 1'b0, rdy_n, max_run, done_n, first_done);
    post_check("wrap", done_n, first_done);

    req_q = {mk(3'b111, 3'd4, 3'd4, 6'h11),
             mk(3'b001, 3'd3, 3'd6, 6'h00)};
    do_load(8'h40, 8'd2, 1'b1, rdy_n, max_run, done_n, first_done);
    post_check("illegal", done_n, first_done);
    chk("illegal_err_set", Err, 1);

    req_q.delete();
    do_load(8'h00, 8'd0, 1'b1, rdy_n, max_run, done_n, first_done);
    post_check("zero", done_n, first_done);
    chk("zero_err_cleared", Err, 0);
    chk("zero_done_next", first_done, 0);
    chk("zero_ready_never", rdy_n, 0);

    req_q.delete();
    for (int i = 0; i < 6; i++)
      req_q.push_back(mk(3'b001, 3'($urandom), 3'($urandom), 6'h00));
    do_load(8'h80, 8'd6, 1'b1, rdy_n, max_run, done_n, first_done);
    post_check("rate", done_n, first_done);
    chk("rate_ready_cycles", rdy_n, 6);
    chk("rate_we_run", max_run, 6);

    // Reset after two writes of a five-word load
    req_q.delete();
    for (int i = 0; i < 5; i++)
      req_q.push_back(mk(3'b011, 3'($urandom), 3'($urandom), 6'h00));
    @(negedge Clk);
    Start = 1'b1; Base_Addr = 8'h30; Count = 8'd5;
    mdl_addr = 8'h30;
    @(negedge Clk);
    Start = 1'b0;
    wes = 0;
    for (int c = 0; c < 50 && wes < 2; c++) begin
      if (c == 0) begin
        Start = 1'b1; Base_Addr = 8'h55; Count = 8'd1;
      end else Start = 1'b0;
      Req_Valid = (c < 5);
      if (c < 5) drive_req(req_q[c]);
      #1;
      if (Mem_WE) wes++;
      if (Req_Valid && Req_Ready) begin
        exp_q.push_back({mdl_addr, ref_word(req_q[c])});
        mdl_addr = mdl_addr + 8'd1;
      end
      if (wes < 2) @(negedge Clk);
    end
    chk("rst_mid_two_writes", wes, 2);
    chk("rst_mid_busy_before", Busy, 1);
    #1 Reset_n = 1'b0;
    Start = 1'b0;
    Req_Valid = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_mid_we", Mem_WE, 0);
    chk("rst_mid_addr", Mem_Addr, 0);
    chk("rst_mid_wdata", Mem_WData, 0);
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_ready", Req_Ready, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      #1;
      chk("post_rst_idle", {Busy, Req_Ready, Done}, 0);
    end

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 10);
      req_q.delete();
      for (int i = 0; i < n; i++)
        req_q.push_back(mk(3'($urandom), 3'($urandom),
                           3'($urandom), 6'($urandom)));
      do_load(8'($urandom), 8'(n), 1'b0, rdy_n, max_run,
              done_n, first_done);
      post_check("rand", done_n, first_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning encoded-instruction buffer depth (power of 2, min 2).
REQ-002 SHALL have port Clk  in  1  sole clock, rising-edge.
REQ-003 SHALL have port Reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  in  1  one-cycle pulse that begins a load, honoured only in IDLE.
REQ-005 SHALL have port Base_Addr  in  8  first instruction-memory address, latched on Start.
REQ-006 SHALL have port Count  in  8  number of instructions to load, latched on Start.
REQ-007 SHALL have port Req_Valid  in  1  control request present.
REQ-008 SHALL have port Req_Ready  out  1  request accepted this cycle when high with Req_Valid.
REQ-009 SHALL have port Req_Branch  in  1  branch control intent.
REQ-010 SHALL have port Req_ALU_OP  in  1  0 add, 1 logical shift left.
REQ-011 SHALL have port Req_Reg_Write  in  1  writeback intent.
REQ-012 SHALL have port Req_Rd  in  3  destination register field.
REQ-013 SHALL have port Req_Rs  in  3  source register / 3-bit immediate field.
REQ-014 SHALL have port Req_Offset  in  6  branch offset field.
REQ-015 SHALL have port Mem_WE  out  1  instruction-memory write strobe.
REQ-016 SHALL have port Mem_Addr  out  8  write address.
REQ-017 SHALL have port Mem_WData  out  8  encoded instruction.
REQ-018 SHALL have port Busy  out  1  high in LOAD.
REQ-019 SHALL have port Done  out  1  one-cycle pulse in DONE.
REQ-020 SHALL have port Err  out  1  sticky illegal-combination flag.

Function
REQ-021 SHALL encode {Branch,ALU_OP,Reg_Write}: 001 -> op 00; 011 -> op 01; 100 -> op 11; 000 -> op 10 (nop).
REQ-022 SHALL form words: op 00/01 -> {op,Rd,Rs}; op 11 -> {11,Offset}; op 10 -> 8'b10_000000.
REQ-023 SHALL encode any other combination as 8'b10_000000, count it as one instruction, and set Err.
REQ-024 SHALL implement FSM IDLE -> LOAD on Start with Count!=0; IDLE -> DONE on Start with Count==0; LOAD -> DONE when written count equals Count; DONE -> IDLE unconditionally after one cycle.
REQ-025 SHALL drive Req_Ready = (state==LOAD) and buffer not full and accepted count < Count.
REQ-026 SHALL push the encoded word into a DEPTH-entry FIFO on each accepted request; no bypass path.
REQ-027 SHALL, whenever the FIFO is non-empty in LOAD, pop one word per cycle and drive Mem_WE=1 with Mem_WData=head and Mem_Addr=current address, all registered.
REQ-028 SHALL give latency exactly one cycle from accept (into empty FIFO) to Mem_WE.
REQ-029 SHALL increment Mem_Addr after each write, wrapping 8'hFF -> 8'h00.
REQ-030 SHALL allow push and pop in the same cycle, including when full-1 or when empty-before-push is false; occupancy unchanged.
REQ-031 SHALL ignore Start outside IDLE.
REQ-032 SHALL clear Err on an accepted Start; Err otherwise stays set until reset.

Reset
REQ-033 SHALL, on Reset_n low, asynchronously force IDLE, FIFO empty, counters 0, Mem_WE=0, Mem_Addr=0, Mem_WData=0, Req_Ready=0, Busy=0, Done=0, Err=0.
REQ-034 SHALL discard buffered, unwritten words when reset asserts mid-LOAD; no Mem_WE after deassert until a new Start.

Structure
REQ-035 SHALL place the opcode constants (00 add, 01 sll, 11 branch, 10 nop), NOP word, and FSM state encoding in shared package cpu_pkg, shared with the decode logic.
REQ-036 SHALL implement the buffer as sub-module instr_fifo (parameter DEPTH, push/pop/full/empty).

Verification
REQ-037 SHALL test: Start Base=8'h10 Count=3; requests 001 Rd=2 Rs=5, 011 Rd=1 Rs=3, 100 Off=6'h2A -> writes 8'h15@10, 8'h4B@11, 8'hEA@12, then Done pulse, Err=0.
REQ-038 SHALL test: Base=8'hFE Count=3, three nop requests -> writes 8'h80 at FE, FF, 00.
REQ-039 SHALL test: request 111 -> 8'h80 written, Err=1; next Start clears Err.
REQ-040 SHALL test: Count=6, Req_Valid constant, memory side drains at full rate -> Req_Ready high every cycle, 6 consecutive Mem_WE cycles, no loss.
REQ-041 SHALL test: Start with Count=0 -> Done on the next cycle, no Mem_WE, Req_Ready never high.
REQ-042 SHALL test: Reset_n low after 2 of 5 writes -> outputs immediately at reset values; IDLE after release; Start ignored while Busy.
